decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage of the Y86-style core, directly downstream of the fetch stage. It consumes the fetched fields (icode, ifun, rA, rB, valC) and reads operands from an internal 15-entry register file. A scoreboard tracks pending writes and blocks issue on data hazards. Results go to a valid/ready-registered output toward execute. A writeback port from execute updates the register file and clears the scoreboard.

## Interface
- DATA_W, 16: operand/valC width
- NREG, 15: architectural registers r0..r14; id 4'hF = "none"
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction (fetch drives this from working)
- in_ready  out  1  decode accepts this cycle
- icode, ifun, rA, rB  in  4 each  fetched fields
- valC  in  DATA_W  fetched constant
- out_valid  out  1  decode register holds an instruction
- out_ready  in  1  execute accepts
- out_icode, out_ifun  out  4 each  registered copy
- out_valA, out_valB  out  DATA_W  operand values
- out_valC  out  DATA_W  registered valC
- out_dstE  out  4  destination id, 4'hF if none
- wb_en  in  1  writeback strobe
- wb_dst  in  4  writeback register id
- wb_val  in  DATA_W  writeback data
- err  out  1  sticky flag, set when an undefined icode is accepted

## Operation
- Encoding: icode 0 NOP; 1 IRMOV (dst rB, no sources); 2 OP (ifun 0 ADD, 1 SUB, 2 AND, 3 XOR; srcs rA, rB; dst rB); 3 RRMOV (src rA; dst rB); 4..F undefined.
- Undefined icode: accepted, passed downstream as NOP (sources and dst none, values 0), err set. err clears only on reset.
- Source/dst id 4'hF never reads the register file (value 0) and never hits the scoreboard.
- Scoreboard busy[NREG-1:0]: a bit is set when an instruction with that dstE is accepted, and cleared when wb_en is high with that wb_dst.
- Hazard: any used source, or the destination (WAW), has its busy bit set -> no accept.
- in_ready = (!out_valid || out_ready) && !hazard. Accept = in_valid && in_ready.
- On accept: the output register loads the decoded fields and operands, and out_valid=1. Otherwise, if out_ready, out_valid=0. With !out_ready, the output register holds all values unchanged.
- Register file write: on wb_en && wb_dst != 4'hF, regs[wb_dst] <= wb_val. Writes with wb_dst=4'hF are ignored entirely.
- Simultaneous set and clear of the same busy bit: set wins.

## Timing
- Reset values:
  - Outputs: out_valid=0, err=0, out_icode=0, out_ifun=0, out_valA/B/C=0, out_dstE=4'hF.
  - Internal state: all registers 0, busy all 0.
  - in_ready is combinational and equals 1 after reset.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when there is no hazard and out_ready=1.
- The register file updates at the clock edge where wb_en is sampled.
- Reset mid-operation: the output register and scoreboard are discarded and in-flight writebacks are lost. There is no partial state.

## Configuration
- WB_BYPASS_EN defined:
  - A same-cycle writeback is forwarded. A source equal to wb_dst reads wb_val and is treated as not busy that cycle.
  - A dependent instruction is accepted in the same cycle as its producer's writeback.
- WB_BYPASS_EN undefined:
  - Operands come only from the registered file, and hazard uses the registered busy vector.
  - A dependent instruction is accepted on the cycle after the writeback.

## Structure
- Package decode_pkg holds the icode/ifun localparams (I_NOP, I_IRMOV, I_OP, I_RRMOV, ALU_ADD..ALU_XOR), REG_NONE=4'hF, and a decoded-instruction struct.
- Sub-module regfile_15x16: two combinational read ports and one write port, with the optional bypass inside.
- decode_stage holds the scoreboard, hazard logic and output register.

## Test plan
- Reset, then IRMOV $8,%r5 (in 32'h10f50008 fields), out_ready=1 -> next cycle out_valid=1, out_icode=1, out_dstE=5, out_valC=16'h0008, out_valA=out_valB=0; busy[5]=1.
- Follow with SUB %r4,%r5 (2,1,4,5) -> in_ready=0 while busy[5]. Drive wb_en=1, wb_dst=5, wb_val=8:
  - With WB_BYPASS_EN: accepted that cycle, next cycle out_valA=0, out_valB=8, out_dstE=5.
  - Without WB_BYPASS_EN: accepted one cycle later with the same values.
- ADD %r1,%r2 back-to-back with an independent prior instruction -> accepted every cycle, out_valid continuous, out_dstE=2.
- Hold out_ready=0 with out_valid=1 -> outputs stable, in_ready=0. Release -> the next instruction loads on that edge.
- icode=4'h7 -> passed as NOP with out_dstE=4'hF; err=1 and stays 1 until rst_n low.
- Assert rst_n=0 with busy[5]=1 and out_valid=1 -> all outputs at reset values asynchronously, busy cleared, in_ready=1 after release.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings and the decoded-instruction record for the decode stage.
package decode_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 15;

    localparam logic [3:0] I_NOP    = 4'h0;
    localparam logic [3:0] I_IRMOV  = 4'h1;
    localparam logic [3:0] I_OP     = 4'h2;
    localparam logic [3:0] I_RRMOV  = 4'h3;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        src_a;
        logic [3:0]        src_b;
        logic [3:0]        dst_e;
        logic [DATA_W-1:0] val_c;
        logic              undef;
    } decoded_t;

    // Undefined opcodes collapse to a NOP with every field neutral.
    function automatic decoded_t decode_fields(
        input logic [3:0]        icode,
        input logic [3:0]        ifun,
        input logic [3:0]        ra,
        input logic [3:0]        rb,
        input logic [DATA_W-1:0] valc
    );
        decoded_t d;
        d.icode = icode;
        d.ifun  = ifun;
        d.src_a = REG_NONE;
        d.src_b = REG_NONE;
        d.dst_e = REG_NONE;
        d.val_c = valc;
        d.undef = 1'b0;
        case (icode)
            I_NOP: ;
            I_IRMOV: d.dst_e = rb;
            I_OP: begin
                d.src_a = ra;
                d.src_b = rb;
                d.dst_e = rb;
            end
            I_RRMOV: begin
                d.src_a = ra;
                d.dst_e = rb;
            end
            default: begin
                d.icode = I_NOP;
                d.ifun  = 4'h0;
                d.val_c = '0;
                d.undef = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute/writeback signal bundle around the decode stage.
interface decode_stage_if import decode_pkg::*; ();

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [DATA_W-1:0] valC;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_icode;
    logic [3:0]        out_ifun;
    logic [DATA_W-1:0] out_valA;
    logic [DATA_W-1:0] out_valB;
    logic [DATA_W-1:0] out_valC;
    logic [3:0]        out_dstE;

    logic              wb_en;
    logic [3:0]        wb_dst;
    logic [DATA_W-1:0] wb_val;

    logic              err;

    modport slave (
        input  in_valid, icode, ifun, rA, rB, valC, out_ready, wb_en, wb_dst, wb_val,
        output in_ready, out_valid, out_icode, out_ifun, out_valA, out_valB, out_valC,
               out_dstE, err
    );

    modport master (
        output in_valid, icode, ifun, rA, rB, valC, out_ready, wb_en, wb_dst, wb_val,
        input  in_ready, out_valid, out_icode, out_ifun, out_valA, out_valB, out_valC,
               out_dstE, err
    );

endinterface

// File: rtl/regfile_15x16.sv
// 15-entry register file, two combinational reads, one write.
// WB_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile_15x16 import decode_pkg::*; (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && wr_addr != REG_NONE) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Id REG_NONE means "no operand" and always reads as zero.
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != REG_NONE) begin
            rd_data_a = regs_q[rd_addr_a];
`ifdef WB_BYPASS_EN
            if (wr_en && wr_addr == rd_addr_a) begin
                rd_data_a = wr_data;
            end
`endif
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != REG_NONE) begin
            rd_data_b = regs_q[rd_addr_b];
`ifdef WB_BYPASS_EN
            if (wr_en && wr_addr == rd_addr_b) begin
                rd_data_b = wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: operand read, scoreboard hazard check, registered output.
// WB_BYPASS_EN lets a same-cycle writeback satisfy a pending dependency.
module decode_stage import decode_pkg::*; (
    input  logic          clock,
    input  logic          rst_n,
    decode_stage_if.slave bus
);

    decoded_t          dec;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [NREG-1:0]   busy_set;
    logic [NREG-1:0]   busy_clr;
    logic [NREG-1:0]   busy_eff;
    logic              hazard;
    logic              in_ready;
    logic              accept;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    logic              out_valid_q;
    logic [3:0]        out_icode_q;
    logic [3:0]        out_ifun_q;
    logic [DATA_W-1:0] out_val_a_q;
    logic [DATA_W-1:0] out_val_b_q;
    logic [DATA_W-1:0] out_val_c_q;
    logic [3:0]        out_dst_e_q;
    logic              err_q;

    assign dec = decode_fields(bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC);

    function automatic logic reg_busy(input logic [3:0] id, input logic [NREG-1:0] vec);
        return (id != REG_NONE) ? vec[id] : 1'b0;
    endfunction

    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        assign busy_clr[gi] = bus.wb_en && (bus.wb_dst == 4'(gi));
        assign busy_set[gi] = accept && (dec.dst_e == 4'(gi));
    end

`ifdef WB_BYPASS_EN
    assign busy_eff = busy_q & ~busy_clr;
`else
    assign busy_eff = busy_q;
`endif

    assign hazard   = reg_busy(dec.src_a, busy_eff) | reg_busy(dec.src_b, busy_eff)
                    | reg_busy(dec.dst_e, busy_eff);
    assign in_ready = (!out_valid_q || bus.out_ready) && !hazard;
    assign accept   = bus.in_valid && in_ready;

    // Set is applied after clear so a new producer wins over a retiring one.
    assign busy_d   = (busy_q & ~busy_clr) | busy_set;

    regfile_15x16 u_regfile (
        .clock     (clock),
        .rst_n     (rst_n),
        .rd_addr_a (dec.src_a),
        .rd_addr_b (dec.src_b),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b),
        .wr_en     (bus.wb_en),
        .wr_addr   (bus.wb_dst),
        .wr_data   (bus.wb_val)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_icode_q <= I_NOP;
            out_ifun_q  <= 4'h0;
            out_val_a_q <= '0;
            out_val_b_q <= '0;
            out_val_c_q <= '0;
            out_dst_e_q <= REG_NONE;
            err_q       <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_icode_q <= dec.icode;
                out_ifun_q  <= dec.ifun;
                out_val_a_q <= rd_a;
                out_val_b_q <= rd_b;
                out_val_c_q <= dec.val_c;
                out_dst_e_q <= dec.dst_e;
                if (dec.undef) begin
                    err_q <= 1'b1;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_icode = out_icode_q;
    assign bus.out_ifun  = out_ifun_q;
    assign bus.out_valA  = out_val_a_q;
    assign bus.out_valB  = out_val_b_q;
    assign bus.out_valC  = out_val_c_q;
    assign bus.out_dstE  = out_dst_e_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expectations follow WB_BYPASS_EN when defined.
module tb_decode_stage;
    import decode_pkg::*;

    logic clock;
    logic rst_n;
    int   n_checks;
    int   n_bad;

    decode_stage_if bus ();

    decode_stage dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [15:0] vc);
        bus.in_valid = 1'b1;
        bus.icode    = ic;
        bus.ifun     = fn;
        bus.rA       = ra;
        bus.rB       = rb;
        bus.valC     = vc;
        $display("txn: icode=%0h ifun=%0h rA=%0h rB=%0h valC=%0h", ic, fn, ra, rb, vc);
    endtask

    task automatic writeback(input logic [3:0] dst, input logic [15:0] val);
        bus.wb_en  = 1'b1;
        bus.wb_dst = dst;
        bus.wb_val = val;
        $display("txn: writeback r%0h <= %0h", dst, val);
    endtask

    initial begin
        n_checks      = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.icode     = 4'h0;
        bus.ifun      = 4'h0;
        bus.rA        = 4'hF;
        bus.rB        = 4'hF;
        bus.valC      = 16'h0;
        bus.out_ready = 1'b1;
        bus.wb_en     = 1'b0;
        bus.wb_dst    = 4'hF;
        bus.wb_val    = 16'h0;

        @(negedge clock);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_err",       32'(bus.err),       32'h0);
        check("rst_icode",     32'(bus.out_icode), 32'h0);
        check("rst_valC",      32'(bus.out_valC),  32'h0);
        check("rst_dstE",      32'(bus.out_dstE),  32'hF);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // IRMOV $8,%r5
        drive(I_IRMOV, 4'h0, 4'hF, 4'h5, 16'h0008);
        #1 check("irmov_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("irmov_valid", 32'(bus.out_valid), 32'h1);
        check("irmov_icode", 32'(bus.out_icode), 32'h1);
        check("irmov_dstE",  32'(bus.out_dstE),  32'h5);
        check("irmov_valC",  32'(bus.out_valC),  32'h0008);
        check("irmov_valA",  32'(bus.out_valA),  32'h0);
        check("irmov_valB",  32'(bus.out_valB),  32'h0);

        // SUB %r4,%r5 blocked by busy r5
        drive(I_OP, ALU_SUB, 4'h4, 4'h5, 16'h0);
        #1 check("sub_blocked", 32'(bus.in_ready), 32'h0);
        step();
        check("sub_not_issued", 32'(bus.out_valid), 32'h0);
        writeback(4'h5, 16'h0008);
`ifdef WB_BYPASS_EN
        #1 check("sub_wb_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.wb_en = 1'b0;
`else
        #1 check("sub_wb_ready", 32'(bus.in_ready), 32'h0);
        step();
        bus.wb_en = 1'b0;
        #1 check("sub_after_wb_ready", 32'(bus.in_ready), 32'h1);
        step();
`endif
        check("sub_valid", 32'(bus.out_valid), 32'h1);
        check("sub_icode", 32'(bus.out_icode), 32'h2);
        check("sub_ifun",  32'(bus.out_ifun),  32'h1);
        check("sub_valA",  32'(bus.out_valA),  32'h0);
        check("sub_valB",  32'(bus.out_valB),  32'h8);
        check("sub_dstE",  32'(bus.out_dstE),  32'h5);

        // SUB re-marked r5 busy, so a reader of r5 must stall
        drive(I_RRMOV, 4'h0, 4'h5, 4'h6, 16'h0);
        #1 check("r5_busy_again", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 1'b0;
        writeback(4'h5, 16'h0008);
        step();
        writeback(4'h1, 16'h0003);
        step();
        writeback(4'h2, 16'h0004);
        step();
        bus.wb_en = 1'b0;

        // independent IRMOV then ADD %r1,%r2 back-to-back
        drive(I_IRMOV, 4'h0, 4'hF, 4'h9, 16'h0007);
        step();
        check("pre_valid", 32'(bus.out_valid), 32'h1);
        check("pre_dstE",  32'(bus.out_dstE),  32'h9);
        drive(I_OP, ALU_ADD, 4'h1, 4'h2, 16'h0);
        #1 check("add_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("add_valid", 32'(bus.out_valid), 32'h1);
        check("add_dstE",  32'(bus.out_dstE),  32'h2);
        check("add_valA",  32'(bus.out_valA),  32'h3);
        check("add_valB",  32'(bus.out_valB),  32'h4);

        // backpressure holds the output register
        bus.out_ready = 1'b0;
        drive(I_RRMOV, 4'h0, 4'h1, 4'h3, 16'h0);
        #1 check("stall_ready", 32'(bus.in_ready), 32'h0);
        step();
        check("stall_valid", 32'(bus.out_valid), 32'h1);
        check("stall_dstE",  32'(bus.out_dstE),  32'h2);
        check("stall_valA",  32'(bus.out_valA),  32'h3);
        bus.out_ready = 1'b1;
        #1 check("release_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("rrmov_icode", 32'(bus.out_icode), 32'h3);
        check("rrmov_dstE",  32'(bus.out_dstE),  32'h3);
        check("rrmov_valA",  32'(bus.out_valA),  32'h3);
        check("rrmov_valB",  32'(bus.out_valB),  32'h0);

        // undefined icode becomes NOP and sets err
        drive(4'h7, 4'h2, 4'h1, 4'h4, 16'h1234);
        #1 check("undef_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("undef_valid", 32'(bus.out_valid), 32'h1);
        check("undef_icode", 32'(bus.out_icode), 32'h0);
        check("undef_ifun",  32'(bus.out_ifun),  32'h0);
        check("undef_dstE",  32'(bus.out_dstE),  32'hF);
        check("undef_valC",  32'(bus.out_valC),  32'h0);
        check("undef_valA",  32'(bus.out_valA),  32'h0);
        check("undef_err",   32'(bus.err),       32'h1);
        bus.in_valid = 1'b0;
        step();
        check("err_sticky",  32'(bus.err),       32'h1);
        check("drain_valid", 32'(bus.out_valid), 32'h0);

        // asynchronous reset with r5 busy and output valid
        drive(I_IRMOV, 4'h0, 4'hF, 4'h5, 16'h0001);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("prerst_valid", 32'(bus.out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'h0);
        check("arst_err",   32'(bus.err),       32'h0);
        check("arst_dstE",  32'(bus.out_dstE),  32'hF);
        check("arst_valC",  32'(bus.out_valC),  32'h0);
        check("arst_icode", 32'(bus.out_icode), 32'h0);
        @(negedge clock);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        drive(I_RRMOV, 4'h0, 4'h5, 4'h6, 16'h0);
        #1 check("post_rst_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("post_rst_valid", 32'(bus.out_valid), 32'h1);
        check("post_rst_valA",  32'(bus.out_valA),  32'h0);
        bus.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
